// File: rtl/eq_i2c_pkg.sv
// Shared types and constants for the equalizer's I2C gain-register target.
package eq_i2c_pkg;

    localparam int         GAIN_W             = 8;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h6A;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_REG,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP.
// Every output is registered, so a pin edge shows up as a pulse 3 clk later,
// and sda_s is the SDA level aligned with those pulses.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;

    // Two-flop synchronizers, previous-value flops and registered edge/condition pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_prev  <= 1'b1;
            sda_prev  <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_s     <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[0], scl_in};
            sda_sync  <= {sda_sync[0], sda_in};
            scl_prev  <= scl_sync[1];
            sda_prev  <= sda_sync[1];
            scl_rise  <= scl_sync[1] & ~scl_prev;
            scl_fall  <= ~scl_sync[1] & scl_prev;
            start_det <= scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
            stop_det  <= scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];
            sda_s     <= sda_sync[1];
        end
    end

endmodule

// File: rtl/i2c_gain_regs_slave.sv
// I2C target holding the per-band equalizer gains. Accepts write bursts with
// pointer auto-increment and read-back through a repeated START.
module i2c_gain_regs_slave
    import eq_i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int         NUM_REGS   = 10,
    parameter logic [7:0] GAIN_RESET = 8'h00
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       scl_in,
    input  logic                       sda_in,
    output logic                       sda_oe,
    output logic [GAIN_W*NUM_REGS-1:0] gain_o,
    output logic                       gain_update,
    output logic                       busy
);

    localparam int               PTR_W      = $clog2(NUM_REGS) + 1;
    localparam int               IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [PTR_W-1:0] PTR_LIMIT  = PTR_W'(NUM_REGS);
    localparam logic [7:0]       NUM_REGS_B = 8'(NUM_REGS);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_state_t        state;
    i2c_state_t        ack_next;
    logic [3:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic [PTR_W-1:0]  ptr;
    logic              ack_go;
    logic              written;
    logic              rd_ack_ok;
    logic [GAIN_W-1:0] regs [NUM_REGS];

    logic [7:0] rx_byte;
    logic       ptr_valid;
    logic [7:0] rd_byte;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    // The byte as it will look once the bit on the current rising edge is shifted in
    assign rx_byte   = {shift_reg[6:0], sda_s};
    assign ptr_valid = (ptr < PTR_LIMIT);
    assign rd_byte   = ptr_valid ? regs[ptr[IDX_W-1:0]] : 8'h00;

    genvar k;
    generate
        for (k = 0; k < NUM_REGS; k++) begin : g_gain_out
            assign gain_o[GAIN_W*k +: GAIN_W] = regs[k];
        end
    endgenerate

    // Protocol FSM: START/STOP override everything, otherwise bits move on SCL edges.
    // bit_cnt 0..7 counts data bits, 8 waits for the falling edge that opens the
    // ACK slot, 9 waits for the falling edge that closes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ack_next    <= ST_IDLE;
            bit_cnt     <= 4'd0;
            shift_reg   <= 8'h00;
            ptr         <= '0;
            ack_go      <= 1'b0;
            written     <= 1'b0;
            rd_ack_ok   <= 1'b0;
            sda_oe      <= 1'b0;
            gain_update <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= GAIN_RESET;
            end
        end else begin
            gain_update <= 1'b0;
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                busy    <= 1'b1;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state       <= ST_IDLE;
                bit_cnt     <= 4'd0;
                busy        <= 1'b0;
                sda_oe      <= 1'b0;
                gain_update <= written;
                written     <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_REG, ST_WR_DATA: begin
                        if (scl_rise && (bit_cnt < 4'd8)) begin
                            shift_reg <= rx_byte;
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                case (state)
                                    ST_ADDR: begin
                                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                                            ack_go <= 1'b1;
                                            case (rx_byte[0])
                                                I2C_RW_READ:  ack_next <= ST_RD_DATA;
                                                I2C_RW_WRITE: ack_next <= ST_REG;
                                                default:      ack_next <= ST_IGNORE;
                                            endcase
                                        end else begin
                                            ack_go <= 1'b0;
                                            state  <= ST_IGNORE;
                                        end
                                    end
                                    ST_REG: begin
                                        if (rx_byte < NUM_REGS_B) begin
                                            ptr      <= rx_byte[PTR_W-1:0];
                                            ack_go   <= 1'b1;
                                            ack_next <= ST_WR_DATA;
                                        end else begin
                                            ack_go <= 1'b0;
                                            state  <= ST_IGNORE;
                                        end
                                    end
                                    default: begin
                                        ack_next <= ST_WR_DATA;
                                        if (ptr_valid) begin
                                            regs[ptr[IDX_W-1:0]] <= rx_byte;
                                            written              <= 1'b1;
                                            ack_go               <= 1'b1;
                                            ptr                  <= ptr + 1'b1;
                                        end else begin
                                            ack_go <= 1'b0;
                                        end
                                    end
                                endcase
                            end
                        end else if (scl_fall && (bit_cnt == 4'd8)) begin
                            sda_oe  <= ack_go;
                            bit_cnt <= 4'd9;
                        end else if (scl_fall && (bit_cnt == 4'd9)) begin
                            bit_cnt <= 4'd0;
                            state   <= ack_next;
                            if (ack_next == ST_RD_DATA) begin
                                shift_reg <= rd_byte;
                                sda_oe    <= ~rd_byte[7];
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_rise && (bit_cnt < 4'd8)) begin
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            bit_cnt   <= bit_cnt + 4'd1;
                            if ((bit_cnt == 4'd7) && ptr_valid) begin
                                ptr <= ptr + 1'b1;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= ST_RD_ACK;
                            end else begin
                                sda_oe <= ~shift_reg[7];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise && (bit_cnt == 4'd0)) begin
                            rd_ack_ok <= ~sda_s;
                            bit_cnt   <= 4'd1;
                        end else if (scl_fall && (bit_cnt == 4'd1)) begin
                            bit_cnt <= 4'd0;
                            if (rd_ack_ok) begin
                                state     <= ST_RD_DATA;
                                shift_reg <= rd_byte;
                                sda_oe    <= ~rd_byte[7];
                            end else begin
                                state  <= ST_IGNORE;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_gain_regs_slave.sv
// Directed bench for i2c_gain_regs_slave: a bit-banged I2C master with SCL
// high/low of 5 clk and SDA changing 1 clk before each SCL rise.
module tb_i2c_gain_regs_slave;

    localparam int NUM_REGS = 10;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  scl;
    logic                  sda_m;
    logic                  sda_line;
    logic                  sda_oe;
    logic [8*NUM_REGS-1:0] gain_o;
    logic                  gain_update;
    logic                  busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int upd_count   = 0;
    int last_upd    = 0;
    int stop_cycle  = 0;

    logic [7:0] model   [NUM_REGS];
    logic [7:0] tx_data [16];

    // Open-drain bus: the target pulling low wins over the master's level
    assign sda_line = sda_oe ? 1'b0 : sda_m;

    i2c_gain_regs_slave #(
        .SLAVE_ADDR (7'h6A),
        .NUM_REGS   (NUM_REGS),
        .GAIN_RESET (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scl_in      (scl),
        .sda_in      (sda_line),
        .sda_oe      (sda_oe),
        .gain_o      (gain_o),
        .gain_update (gain_update),
        .busy        (busy)
    );

    // 50 MHz system clock
    always #10 clk = ~clk;

    // Free-running cycle counter used to time the gain_update pulse
    always @(posedge clk) cyc <= cyc + 1;

    // Count gain_update pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (gain_update === 1'b1) begin
            upd_count = upd_count + 1;
            last_upd  = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        vectors = vectors + 1;
        assert (observed === expected) else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [79:0] packModel();
        logic [79:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) v[8*i +: 8] = model[i];
        return v;
    endfunction

    task automatic clockBit(input logic b, output logic sampled);
        waitClk(4);
        sda_m = b;
        waitClk(1);
        scl = 1'b1;
        waitClk(2);
        sampled = sda_line;
        waitClk(3);
        scl = 1'b0;
    endtask

    task automatic i2cStart();
        if (scl == 1'b0) begin
            waitClk(4);
            sda_m = 1'b1;
            waitClk(1);
            scl = 1'b1;
            waitClk(5);
        end else begin
            sda_m = 1'b1;
            waitClk(5);
        end
        sda_m = 1'b0;
        waitClk(5);
        scl = 1'b0;
    endtask

    task automatic i2cStop();
        waitClk(4);
        sda_m = 1'b0;
        waitClk(1);
        scl = 1'b1;
        waitClk(5);
        sda_m = 1'b1;
        stop_cycle = cyc;
        waitClk(5);
    endtask

    // Send one byte MSB first and report whether the target ACKed it
    task automatic applyStimulus(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clockBit(b[i], s);
        clockBit(1'b1, s);
        acked = ~s;
    endtask

    task automatic readByte(input logic master_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clockBit(1'b1, s);
            d[i] = s;
        end
        clockBit(~master_ack, s);
    endtask

    task automatic writeBurst(input logic [7:0] ptr, input int n, output int ack_count);
        logic a;
        ack_count = 0;
        i2cStart();
        applyStimulus(8'hD4, a);
        if (a) ack_count++;
        applyStimulus(ptr, a);
        if (a) ack_count++;
        for (int i = 0; i < n; i++) begin
            applyStimulus(tx_data[i], a);
            if (a) ack_count++;
        end
        i2cStop();
    endtask

    // Linear sequence of directed steps
    initial begin
        int         acks;
        int         u0;
        logic       a;
        logic [7:0] d;

        rst   = 1'b1;
        scl   = 1'b1;
        sda_m = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
        waitClk(3);
        checkOutput("reset_gain", 80'(gain_o), packModel());
        checkOutput("reset_busy", 80'(busy), 80'd0);
        checkOutput("reset_sda_oe", 80'(sda_oe), 80'd0);
        checkOutput("reset_update", 80'(gain_update), 80'd0);
        rst = 1'b0;
        waitClk(5);

        $display("[TB] write burst of ten 0xFF at pointer 0");
        u0 = upd_count;
        acks = 0;
        i2cStart();
        checkOutput("busy_after_start", 80'(busy), 80'd1);
        applyStimulus(8'hD4, a);
        if (a) acks++;
        applyStimulus(8'h00, a);
        if (a) acks++;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'hFF, a);
            if (a) acks++;
        end
        checkOutput("burst_acks", 80'(acks), 80'd12);
        i2cStop();
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'hFF;
        checkOutput("burst_gain", 80'(gain_o), packModel());
        checkOutput("burst_update_count", 80'(upd_count - u0), 80'd1);
        checkOutput("burst_update_latency", 80'(((last_upd - stop_cycle) >= 1) && ((last_upd - stop_cycle) <= 4)), 80'd1);
        checkOutput("busy_after_stop", 80'(busy), 80'd0);

        $display("[TB] wrong address 0xA0");
        u0 = upd_count;
        i2cStart();
        applyStimulus(8'hA0, a);
        checkOutput("wrong_addr_ack", 80'(a), 80'd0);
        i2cStop();
        checkOutput("wrong_addr_gain", 80'(gain_o), packModel());
        checkOutput("wrong_addr_update", 80'(upd_count - u0), 80'd0);

        $display("[TB] write 0x11 0x22 0x33 at pointer 3, then read back");
        u0 = upd_count;
        tx_data[0] = 8'h11;
        tx_data[1] = 8'h22;
        tx_data[2] = 8'h33;
        writeBurst(8'h03, 3, acks);
        checkOutput("ptr3_write_acks", 80'(acks), 80'd5);
        model[3] = 8'h11;
        model[4] = 8'h22;
        model[5] = 8'h33;
        checkOutput("ptr3_write_gain", 80'(gain_o), packModel());
        checkOutput("ptr3_write_update", 80'(upd_count - u0), 80'd1);

        u0 = upd_count;
        acks = 0;
        i2cStart();
        applyStimulus(8'hD4, a);
        if (a) acks++;
        applyStimulus(8'h03, a);
        if (a) acks++;
        i2cStart();
        applyStimulus(8'hD5, a);
        if (a) acks++;
        checkOutput("readback_acks", 80'(acks), 80'd3);
        readByte(1'b1, d);
        checkOutput("readback_byte0", 80'(d), 80'h11);
        readByte(1'b1, d);
        checkOutput("readback_byte1", 80'(d), 80'h22);
        readByte(1'b0, d);
        checkOutput("readback_byte2", 80'(d), 80'h33);
        i2cStop();
        checkOutput("readback_update", 80'(upd_count - u0), 80'd0);

        $display("[TB] out-of-range pointers");
        u0 = upd_count;
        i2cStart();
        applyStimulus(8'hD4, a);
        applyStimulus(8'h0A, a);
        checkOutput("ptr10_ack", 80'(a), 80'd0);
        i2cStop();
        checkOutput("ptr10_gain", 80'(gain_o), packModel());
        checkOutput("ptr10_update", 80'(upd_count - u0), 80'd0);

        u0 = upd_count;
        tx_data[0] = 8'h5A;
        tx_data[1] = 8'h6B;
        writeBurst(8'h09, 2, acks);
        checkOutput("ptr9_acks", 80'(acks), 80'd3);
        model[9] = 8'h5A;
        checkOutput("ptr9_gain", 80'(gain_o), packModel());
        checkOutput("ptr9_update", 80'(upd_count - u0), 80'd1);

        i2cStart();
        applyStimulus(8'hD4, a);
        applyStimulus(8'h09, a);
        i2cStart();
        applyStimulus(8'hD5, a);
        readByte(1'b1, d);
        checkOutput("read_reg9", 80'(d), 80'h5A);
        readByte(1'b0, d);
        checkOutput("read_past_end", 80'(d), 80'h00);
        i2cStop();

        $display("[TB] reset during the 4th data bit");
        i2cStart();
        applyStimulus(8'hD4, a);
        applyStimulus(8'h00, a);
        for (int i = 0; i < 3; i++) clockBit(1'b0, a);
        waitClk(4);
        sda_m = 1'b1;
        waitClk(1);
        scl = 1'b1;
        waitClk(2);
        checkOutput("busy_mid_byte", 80'(busy), 80'd1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
        checkOutput("rst_sda_oe", 80'(sda_oe), 80'd0);
        checkOutput("rst_busy", 80'(busy), 80'd0);
        checkOutput("rst_gain", 80'(gain_o), packModel());
        waitClk(3);
        rst = 1'b0;
        waitClk(5);

        $display("[TB] full write after reset");
        u0 = upd_count;
        for (int i = 0; i < 10; i++) begin
            tx_data[i] = 8'(i + 1);
            model[i]   = 8'(i + 1);
        end
        writeBurst(8'h00, 10, acks);
        checkOutput("post_rst_acks", 80'(acks), 80'd12);
        checkOutput("post_rst_gain", 80'(gain_o), packModel());
        checkOutput("post_rst_update", 80'(upd_count - u0), 80'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
